// File: rtl/ofm_packer.sv
// ofm_packer: round, optional leaky ReLU and 16-bit saturate each accumulator, pack 16 lanes per word.
// Latency 3 cycles from accept to write; in_ready is throttled by a credit count of downstream FIFO occupancy.
module ofm_packer #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int AXI_WIDTH  = 256,
    parameter int FIFO_SIZE  = 768,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_leaky,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACC_WIDTH-1:0]  in_acc,
    input  logic                  in_last,
    output logic                  write,
    output logic [AXI_WIDTH-1:0]  WDATA_IN,
    input  logic                  rd_pulse,
    output logic [15:0]           word_cnt,
    output logic                  done_pulse,
    output logic                  credit_err
);

    localparam int LANES  = AXI_WIDTH / DATA_WIDTH;
    localparam int LANE_W = $clog2(LANES);
    localparam int SW     = ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] RND       = SW'((2 ** FRAC_SHIFT) / 2);
    localparam logic signed [SW-1:0] SAT_MAX   = SW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic        [10:0]   OCC_LIMIT = 11'(FIFO_SIZE - 3);
    localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [SW-1:0]   s1_q, s1_d;
    logic                   s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0]  s2_q, s2_d;
    logic                   s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [AXI_WIDTH-1:0]   pack_q, pack_d;
    logic [AXI_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   write_q, write_d, wlast_q, wlast_d;
    logic [10:0]            occ_q, occ_d;
    logic                   in_ready_q, in_ready_d;
    logic [15:0]            word_cnt_q, word_cnt_d;
    logic                   done_q, done_d;
    logic                   cerr_q, cerr_d;

    logic                   xfer;
    logic signed [SW-1:0]   acc_ext;
    logic signed [SW-1:0]   lk;
    logic [AXI_WIDTH-1:0]   word;

    always_comb begin
        xfer    = in_valid && in_ready_q;
        acc_ext = {in_acc[ACC_WIDTH-1], in_acc};

        // One extra bit of headroom so the rounding add cannot wrap.
        if (FRAC_SHIFT == 0) s1_d = acc_ext;
        else                 s1_d = (acc_ext + RND) >>> FRAC_SHIFT;
        s1_vld_d  = xfer;
        s1_last_d = xfer && in_last;

        lk = (cfg_leaky && (s1_q < 0)) ? (s1_q >>> 3) : s1_q;
        if (lk > SAT_MAX)      s2_d = SAT_MAX[DATA_WIDTH-1:0];
        else if (lk < SAT_MIN) s2_d = SAT_MIN[DATA_WIDTH-1:0];
        else                   s2_d = lk[DATA_WIDTH-1:0];
        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;

        word = pack_q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LANE_W'(i)) word[i*DATA_WIDTH +: DATA_WIDTH] = s2_q;
        end
        pack_d  = pack_q;
        lane_d  = lane_q;
        write_d = 1'b0;
        wlast_d = 1'b0;
        wdata_d = wdata_q;
        if (s2_vld_q) begin
            if (lane_q == LANE_LAST || s2_last_q) begin
                write_d = 1'b1;
                wlast_d = s2_last_q;
                wdata_d = word;
                pack_d  = '0;
                lane_d  = '0;
            end else begin
                pack_d = word;
                lane_d = lane_q + 1'b1;
            end
        end

        occ_d  = occ_q;
        cerr_d = cerr_q;
        case ({write_q, rd_pulse})
            2'b10: occ_d = occ_q + 11'd1;
            2'b01: begin
                if (occ_q == 11'd0) cerr_d = 1'b1;
                else                occ_d  = occ_q - 11'd1;
            end
            default: ;
        endcase

        word_cnt_d = word_cnt_q;
        if (state_q == IDLE && xfer) word_cnt_d = 16'd0;
        if (write_q)                 word_cnt_d = word_cnt_d + 16'd1;

        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:   if (xfer) state_d = in_last ? DRAIN : ACTIVE;
            ACTIVE: if (xfer && in_last) state_d = DRAIN;
            DRAIN: begin
                if (write_q && wlast_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Two words of headroom: values still in stages 1-2 plus a last-flush.
        in_ready_d = (state_d == IDLE || state_d == ACTIVE) && (occ_d <= OCC_LIMIT);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_q       <= '0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            lane_q     <= '0;
            pack_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            wlast_q    <= 1'b0;
            occ_q      <= '0;
            in_ready_q <= 1'b1;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            cerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            s2_q       <= s2_d;
            s2_vld_q   <= s2_vld_d;
            s2_last_q  <= s2_last_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            wlast_q    <= wlast_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            cerr_q     <= cerr_d;
        end
    end

    assign in_ready   = in_ready_q && !ARESET;
    assign write      = write_q;
    assign WDATA_IN   = wdata_q;
    assign word_cnt   = word_cnt_q;
    assign done_pulse = done_q;
    assign credit_err = cerr_q;

endmodule

// File: tb/tb_ofm_packer.sv
// Scoreboard bench for ofm_packer: stimulus pushes expected words, a negedge monitor pops on write.
module tb_ofm_packer;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         cfg_leaky;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_acc;
    logic         in_last;
    logic         write;
    logic [255:0] WDATA_IN;
    logic         rd_pulse;
    logic [15:0]  word_cnt;
    logic         done_pulse;
    logic         credit_err;

    always #5 ACLK = ~ACLK;

    ofm_packer dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .cfg_leaky  (cfg_leaky),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_acc     (in_acc),
        .in_last    (in_last),
        .write      (write),
        .WDATA_IN   (WDATA_IN),
        .rd_pulse   (rd_pulse),
        .word_cnt   (word_cnt),
        .done_pulse (done_pulse),
        .credit_err (credit_err)
    );

    int           n_vec = 0;
    int           n_err = 0;
    logic [255:0] exp_q[$];
    logic [255:0] bw;
    int           bl;
    int           occ_m;
    int           occ_pk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_lane(input logic [15:0] v, input bit last);
        bw[bl*16 +: 16] = v;
        if (bl == 15 || last) begin
            exp_q.push_back(bw);
            bw = '0;
            bl = 0;
        end else begin
            bl++;
        end
    endtask

    // Monitor: checks every emitted word and models FIFO occupancy seen by the next edge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            occ_m = 0;
        end else begin
            if (write) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got %0h expected no write", WDATA_IN);
                end else begin
                    chk("word", WDATA_IN, exp_q.pop_front());
                end
            end
            if (write && !rd_pulse) occ_m++;
            else if (!write && rd_pulse && occ_m > 0) occ_m--;
            if (occ_m > occ_pk) occ_pk = occ_m;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input bit l);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_acc   = a;
        in_last  = l;
        while (!in_ready && w < 2000) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_l(input logic [31:0] a, input bit lk, input logic [15:0] e, input bit l);
        cfg_leaky = lk;
        exp_lane(e, l);
        send(a, l);
        tick();
        tick();
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge ACLK);
            if (done_pulse) seen = 1'b1;
            else chk({nm, "_rdy_drain"}, in_ready, 0);
        end
        chk({nm, "_done"}, seen, 1);
        tick();
    endtask

    task automatic do_reset(input string nm);
        ARESET = 1'b1;
        tick();
        tick();
        @(negedge ACLK);
        chk({nm, "_rst_rdy"}, in_ready, 0);
        chk({nm, "_rst_write"}, write, 0);
        chk({nm, "_rst_wdata"}, WDATA_IN, 0);
        chk({nm, "_rst_wcnt"}, word_cnt, 0);
        chk({nm, "_rst_done"}, done_pulse, 0);
        chk({nm, "_rst_cerr"}, credit_err, 0);
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        chk({nm, "_post_rdy"}, in_ready, 1);
        tick();
    endtask

    initial begin
        int i;
        int idle;
        int n;
        ARESET    = 1'b1;
        cfg_leaky = 1'b0;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_last   = 1'b0;
        rd_pulse  = 1'b0;
        bw        = '0;
        bl        = 0;
        occ_m     = 0;
        occ_pk    = 0;

        do_reset("t0");

        // 16 values 0x100*(i+1) -> lanes 1..16, write 3 cycles after the 16th transfer
        for (int k = 0; k < 16; k++) begin
            exp_lane(16'(k + 1), 1'b0);
            send(32'(k + 1) << 8, 1'b0);
        end
        for (int d = 0; d < 3; d++) begin
            @(negedge ACLK);
            chk("t1_latency", write, (d == 2));
        end
        @(negedge ACLK);
        chk("t1_wcnt", word_cnt, 1);

        // Saturation and leaky on the same layer; last flushes a 3-lane word
        cfg_leaky = 1'b1;
        exp_lane(16'h7FFF, 1'b0); send(32'h7FFF_FFFF, 1'b0);
        exp_lane(16'h8000, 1'b0); send(32'h8000_0000, 1'b0);
        exp_lane(16'hFFFF, 1'b1); send(32'hFFFF_F800, 1'b1);
        for (int d = 0; d < 5; d++) begin
            @(negedge ACLK);
            chk("t2_write", write, (d == 2));
            chk("t2_done", done_pulse, (d == 3));
            chk("t2_rdy", in_ready, (d == 4));
        end
        chk("t2_wcnt", word_cnt, 2);
        tick();

        // 40 values in a new layer -> 3 words, last one half full
        cfg_leaky = 1'b0;
        for (int k = 0; k < 40; k++) begin
            exp_lane(16'(k + 1), (k == 39));
            send(32'(k + 1) << 8, (k == 39));
            if (k == 0) begin
                @(negedge ACLK);
                chk("t3_wcnt_clear", word_cnt, 0);
            end
        end
        wait_done("t3");
        @(negedge ACLK);
        chk("t3_wcnt", word_cnt, 3);
        tick();

        // Rounding boundaries with cfg_leaky changing per value
        send_l(32'h0000_0180, 1'b0, 16'h0002, 1'b0);
        send_l(32'hFFFF_FF80, 1'b0, 16'h0000, 1'b0);
        send_l(32'hFFFF_FE80, 1'b0, 16'hFFFF, 1'b0);
        send_l(32'hFFFF_F000, 1'b1, 16'hFFFE, 1'b0);
        send_l(32'hFFFF_F000, 1'b0, 16'hFFF0, 1'b0);
        send_l(32'h0000_0500, 1'b1, 16'h0005, 1'b0);
        send_l(32'h00FF_FF00, 1'b1, 16'h7FFF, 1'b0);
        send_l(32'hFF80_0000, 1'b1, 16'hF000, 1'b1);
        wait_done("t4");
        cfg_leaky = 1'b0;

        // Continuous input with no reads until credit runs out
        in_valid = 1'b1;
        in_last  = 1'b0;
        i        = 0;
        idle     = 0;
        for (int c = 0; c < 14000 && idle < 50; c++) begin
            in_acc = 32'(i) << 8;
            if (in_ready) begin
                exp_lane(i[15:0], 1'b0);
                tick();
                i++;
                idle = 0;
            end else begin
                tick();
                idle++;
            end
        end
        in_valid = 1'b0;
        chk("t5_occ_stop", occ_m, 766);
        chk("t5_rdy_low", in_ready, 0);
        rd_pulse = 1'b1;
        @(negedge ACLK);
        chk("t5_rdy_before", in_ready, 0);
        tick();
        rd_pulse = 1'b0;
        @(negedge ACLK);
        chk("t5_rdy_return", in_ready, 1);
        tick();
        exp_lane(16'h1234, 1'b1);
        send(32'h0012_3400, 1'b1);
        tick();
        tick();
        rd_pulse = 1'b1;
        @(negedge ACLK);
        chk("t5_wr_with_rd", write, 1);
        tick();
        rd_pulse = 1'b0;
        wait_done("t5");
        @(negedge ACLK);
        chk("t5_rdy_idle", in_ready, 1);
        tick();

        // Return every credit exactly, then one extra read underflows
        n = occ_m;
        rd_pulse = 1'b1;
        repeat (n) tick();
        rd_pulse = 1'b0;
        @(negedge ACLK);
        chk("t5_cerr_clean", credit_err, 0);
        tick();
        rd_pulse = 1'b1;
        tick();
        rd_pulse = 1'b0;
        @(negedge ACLK);
        chk("t5_cerr_set", credit_err, 1);
        tick();
        rd_pulse = 1'b1;
        tick();
        rd_pulse = 1'b0;
        repeat (5) tick();
        @(negedge ACLK);
        chk("t5_cerr_sticky", credit_err, 1);
        tick();

        // Reset mid-word discards the partial word
        for (int k = 0; k < 7; k++) send(32'(k + 1) << 8, 1'b0);
        chk("t6_cerr_pre", credit_err, 1);
        do_reset("t6");
        repeat (20) tick();
        chk("t6_no_write", exp_q.size(), 0);
        for (int k = 0; k < 16; k++) begin
            exp_lane(16'(k + 17), 1'b0);
            send(32'(k + 17) << 8, 1'b0);
        end
        repeat (5) tick();
        @(negedge ACLK);
        chk("t6_wcnt", word_cnt, 1);

        chk("occ_peak", occ_pk, 766);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
